// File: rtl/nand_net_test_sequencer_if.sv
// ---------------------------------------------------------------------------
// nand_net_test_sequencer_if
//   Bundles the run handshake, the stimulus/response wires to the NAND-network
//   circuit under test, and the result bus of the self-test sequencer.
//
//   Signals
//     start      run request (requester -> sequencer)
//     p_in,q_in  circuit outputs p and q (circuit -> sequencer)
//     a, b       stimulus to circuit inputs (sequencer -> circuit)
//     busy       run in progress (DRIVE or DONE)
//     done       one-cycle pulse when results become valid
//     pass       1 when no vector failed
//     err_count  number of failing vectors, 0..4
//     fail_mask  bit i set if vector index i mismatched
//
//   Modports
//     master  requester / circuit side (drives start, p_in, q_in)
//     slave   sequencer side
// ---------------------------------------------------------------------------
interface nand_net_test_sequencer_if;
  logic       start;
  logic       p_in;
  logic       q_in;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;

  modport master (
    output start, p_in, q_in,
    input  a, b, busy, done, pass, err_count, fail_mask
  );

  modport slave (
    input  start, p_in, q_in,
    output a, b, busy, done, pass, err_count, fail_mask
  );
endinterface

// File: rtl/nand_net_test_sequencer.sv
// ---------------------------------------------------------------------------
// nand_net_test_sequencer
//   Self-test controller for the two-input NAND-network circuit. Steps the
//   circuit inputs {a,b} through 00,01,10,11, holds each vector SETTLE+1
//   cycles, samples p/q on the last edge of the vector and compares them
//   against the expected truth tables. Reports pass, err_count and a
//   per-vector fail_mask with a one-cycle done pulse.
//
//   Parameters
//     SETTLE   extra hold cycles per vector before sampling (0..15)
//     EXP_Q    expected q, bit i for vector index i = {a,b}
//     EXP_P    expected p, same ordering
//     CHECK_P  1 = compare p as well as q
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    sequencer side of nand_net_test_sequencer_if
// ---------------------------------------------------------------------------
module nand_net_test_sequencer #(
  parameter int         SETTLE  = 1,
  parameter logic [3:0] EXP_Q   = 4'b0110,
  parameter logic [3:0] EXP_P   = 4'b0000,
  parameter bit         CHECK_P = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  nand_net_test_sequencer_if.slave   bus
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] fail_mask_q, fail_mask_d;
  logic [2:0] err_count_q, err_count_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  logic       a_o, b_o, busy_o, done_o;

  // 4-state inequality so an X/Z on a compared input is flagged as a failure
  // in simulation rather than silently passing.
  always_comb begin
    mismatch = (bus.q_in !== EXP_Q[idx_q]) ||
               (CHECK_P && (bus.p_in !== EXP_P[idx_q]));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      fail_mask_q <= 4'd0;
      err_count_q <= 3'd0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      fail_mask_q <= fail_mask_d;
      err_count_q <= err_count_d;
      pass_q      <= pass_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    fail_mask_d = fail_mask_q;
    err_count_d = err_count_q;
    pass_d      = pass_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_DRIVE;
          idx_d       = 2'd0;
          cnt_d       = SETTLE_C;
          fail_mask_d = 4'd0;
          err_count_d = 3'd0;
          pass_d      = 1'b0;
        end
      end

      S_DRIVE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Sampling edge for this vector: each vector is visited once, so
          // err_count can reach at most 4 and never wraps.
          if (mismatch) begin
            fail_mask_d[idx_q] = 1'b1;
            err_count_d        = err_count_q + 3'd1;
          end
          if (idx_q == 2'd3) begin
            state_d = S_DONE;
            // Uses the count including the last vector's result.
            pass_d  = (err_count_d == 3'd0);
          end else begin
            idx_d = idx_q + 2'd1;
            cnt_d = SETTLE_C;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: stimulus is only applied while a vector is being driven,
  // so the circuit sees 00 in IDLE, in DONE and immediately after reset.
  always_comb begin
    a_o    = 1'b0;
    b_o    = 1'b0;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_DRIVE: begin
        a_o    = idx_q[1];
        b_o    = idx_q[0];
        busy_o = 1'b1;
      end
      S_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign bus.a         = a_o;
  assign bus.b         = b_o;
  assign bus.busy      = busy_o;
  assign bus.done      = done_o;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;
  assign bus.fail_mask = fail_mask_q;

endmodule
